// File: rtl/tdm_demultiplexer1to4_pkg.sv
// Shared definitions for the 1:4 TDM demultiplexer: frame geometry, FSM encoding
// and the slot-advance helper.
package tdm_demultiplexer1to4_pkg;

    localparam int CH_COUNT = 4;
    localparam int SLOT_W   = 2;

    // Two-bit encoding leaves two unused codes; both recover to ST_HUNT.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_LOCKED = 2'b01
    } state_t;

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/tdm_demultiplexer1to4_decoder2to4.sv
// 2-to-4 one-hot decoder. It turns the slot index into a per-channel write strobe,
// which is the inverse of the 2:1 selection tree in the transmit-side multiplexer.
module decoder2to4
    import tdm_demultiplexer1to4_pkg::*;
(
    input  logic [SLOT_W-1:0]   sel,
    input  logic                en,
    output logic [CH_COUNT-1:0] onehot
);

    // One-hot decode of sel, all-zero when en is low
    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            case (sel)
                2'd0:    onehot = 4'b0001;
                2'd1:    onehot = 4'b0010;
                2'd2:    onehot = 4'b0100;
                2'd3:    onehot = 4'b1000;
                default: onehot = 4'b0000;
            endcase
        end else begin
            onehot = 4'b0000;
        end
    end

endmodule

// File: rtl/tdm_demultiplexer1to4.sv
// Receive side of the 4:1 TDM link: locks onto the channel-0 sync strobe and
// rebuilds each 4-beat frame into a parallel word with a one-cycle valid pulse.
module tdm_demultiplexer1to4
    import tdm_demultiplexer1to4_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int SYNC_EVERY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    input  logic                  in_sync,
    output logic [4*WIDTH-1:0]    out_data,
    output logic                  out_valid,
    output logic [SLOT_W-1:0]     slot,
    output logic                  locked,
    output logic                  sync_error
);

    state_t                state_r;
    logic [SLOT_W-1:0]     slot_r;
    logic                  locked_r;
    logic [4*WIDTH-1:0]    out_data_r;
    logic                  out_valid_r;
    logic                  sync_error_r;
    logic [WIDTH-1:0]      shadow_r [0:CH_COUNT-2];

    logic                  wr_en_s;
    logic [SLOT_W-1:0]     wr_sel_s;
    logic [CH_COUNT-1:0]   we_s;

    // Which channel (if any) the current beat lands in; channel 3 means frame complete
    always_comb begin
        wr_en_s  = 1'b0;
        wr_sel_s = 2'd0;
        if (in_valid) begin
            case (state_r)
                ST_HUNT: begin
                    wr_en_s  = in_sync;
                    wr_sel_s = 2'd0;
                end
                ST_LOCKED: begin
                    if (in_sync) begin
                        wr_en_s  = 1'b1;
                        wr_sel_s = 2'd0;
                    end else if (slot_r != 2'd0) begin
                        wr_en_s  = 1'b1;
                        wr_sel_s = slot_r;
                    end else begin
                        wr_en_s  = (SYNC_EVERY == 0);
                        wr_sel_s = 2'd0;
                    end
                end
                default: begin
                    wr_en_s  = 1'b0;
                    wr_sel_s = 2'd0;
                end
            endcase
        end else begin
            wr_en_s  = 1'b0;
            wr_sel_s = 2'd0;
        end
    end

    decoder2to4 u_decoder (
        .sel    (wr_sel_s),
        .en     (wr_en_s),
        .onehot (we_s)
    );

    // Shadow registers for channels 0..2; channel 3 goes straight to the output word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CH_COUNT - 1; k++) begin
                shadow_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < CH_COUNT - 1; k++) begin
                if (we_s[k]) begin
                    shadow_r[k] <= in_data;
                end
            end
        end
    end

    // Framing FSM, slot counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_HUNT;
            slot_r       <= 2'd0;
            locked_r     <= 1'b0;
            out_data_r   <= {(4*WIDTH){1'b0}};
            out_valid_r  <= 1'b0;
            sync_error_r <= 1'b0;
        end else begin
            out_valid_r  <= 1'b0;
            sync_error_r <= 1'b0;
            if (in_valid) begin
                case (state_r)
                    ST_HUNT: begin
                        if (in_sync) begin
                            state_r  <= ST_LOCKED;
                            locked_r <= 1'b1;
                            slot_r   <= 2'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (in_sync) begin
                            // A misplaced sync resynchronises: the partial frame is dropped
                            sync_error_r <= (slot_r != 2'd0);
                            slot_r       <= 2'd1;
                        end else if (we_s[3]) begin
                            out_data_r  <= {in_data, shadow_r[2], shadow_r[1], shadow_r[0]};
                            out_valid_r <= 1'b1;
                            slot_r      <= 2'd0;
                        end else if (wr_en_s) begin
                            slot_r <= next_slot(slot_r);
                        end else begin
                            sync_error_r <= 1'b1;
                            state_r      <= ST_HUNT;
                            locked_r     <= 1'b0;
                            slot_r       <= 2'd0;
                        end
                    end
                    default: begin
                        state_r  <= ST_HUNT;
                        locked_r <= 1'b0;
                        slot_r   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign slot       = slot_r;
    assign locked     = locked_r;
    assign sync_error = sync_error_r;

endmodule

// File: tb/tb_tdm_demultiplexer1to4.sv
// Directed bench for tdm_demultiplexer1to4: strict-sync, freewheel and 4-bit-lane
// instances share one stimulus stream.
module tb_tdm_demultiplexer1to4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_data = 1'b0;
    logic [3:0]  in_data4 = 4'h0;
    logic        in_valid = 1'b0;
    logic        in_sync = 1'b0;

    logic [3:0]  out_data1, out_data0;
    logic        out_valid1, out_valid0, locked1, locked0, sync_error1, sync_error0;
    logic [1:0]  slot1, slot0, slot4;
    logic [15:0] out_data4;
    logic        out_valid4, locked4, sync_error4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tdm_demultiplexer1to4 #(.WIDTH(1), .SYNC_EVERY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
        .out_data(out_data1), .out_valid(out_valid1), .slot(slot1), .locked(locked1),
        .sync_error(sync_error1));

    tdm_demultiplexer1to4 #(.WIDTH(1), .SYNC_EVERY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
        .out_data(out_data0), .out_valid(out_valid0), .slot(slot0), .locked(locked0),
        .sync_error(sync_error0));

    tdm_demultiplexer1to4 #(.WIDTH(4), .SYNC_EVERY(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data4), .in_valid(in_valid), .in_sync(in_sync),
        .out_data(out_data4), .out_valid(out_valid4), .slot(slot4), .locked(locked4),
        .sync_error(sync_error4));

    // One valid beat; on return the outputs reflect that beat
    task automatic beat(input logic [3:0] d, input logic s);
        @(negedge clk);
        in_data  = d[0];
        in_data4 = d;
        in_valid = 1'b1;
        in_sync  = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic gap(input int n, input logic s);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sync  = s;
            @(posedge clk);
            #1;
        end
        in_sync = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_data1, out_valid1, slot1, locked1, sync_error1} !== 9'h000) begin
            bad++;
            $display("FAIL reset_state got data=%h v=%b slot=%0d lk=%b err=%b expected all 0",
                     out_data1, out_valid1, slot1, locked1, sync_error1);
        end
        total++;
        if ({out_data4, out_valid4, slot4, locked4} !== 20'h0) begin
            bad++;
            $display("FAIL reset_w4 got data=%h v=%b slot=%0d lk=%b expected all 0",
                     out_data4, out_valid4, slot4, locked4);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic_frame;
        beat(4'h1, 1'b1);
        total++;
        if (locked1 !== 1'b1 || slot1 !== 2'd1) begin
            bad++;
            $display("FAIL basic_lock got lk=%b slot=%0d expected lk=1 slot=1", locked1, slot1);
        end
        beat(4'h0, 1'b0);
        beat(4'h1, 1'b0);
        beat(4'h1, 1'b0);
        total++;
        if (out_valid1 !== 1'b1 || out_data1 !== 4'b1101 || slot1 !== 2'd0) begin
            bad++;
            $display("FAIL basic_frame got v=%b data=%b slot=%0d expected v=1 data=1101 slot=0",
                     out_valid1, out_data1, slot1);
        end
        gap(1, 1'b0);
        total++;
        if (out_valid1 !== 1'b0 || out_data1 !== 4'b1101 || locked1 !== 1'b1) begin
            bad++;
            $display("FAIL basic_pulse got v=%b data=%b lk=%b expected v=0 data=1101 lk=1",
                     out_valid1, out_data1, locked1);
        end
    endtask

    // Bench-side 4:1 multiplexer with a slot counter drives the link
    task automatic test_back_to_back;
        logic [3:0] i_word;
        int n;
        int last;
        i_word = 4'hA;
        n = 0;
        last = -1;
        for (int c = 0; c < 12; c++) begin
            beat({3'b000, i_word[c % 4]}, (c % 4) == 0);
            if (out_valid1 === 1'b1) begin
                total++;
                if (out_data1 !== 4'hA) begin
                    bad++;
                    $display("FAIL loop_data got %h expected a", out_data1);
                end
                if (n > 0) begin
                    total++;
                    if (c - last != 4) begin
                        bad++;
                        $display("FAIL loop_spacing got %0d expected 4", c - last);
                    end
                end
                last = c;
                n++;
            end
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL loop_pulses got %0d expected 3", n);
        end
    endtask

    task automatic test_sync_error;
        beat(4'h1, 1'b1);
        beat(4'h1, 1'b0);
        beat(4'h0, 1'b1);
        total++;
        if (sync_error1 !== 1'b1 || out_valid1 !== 1'b0 || slot1 !== 2'd1 ||
            out_data1 !== 4'hA || locked1 !== 1'b1) begin
            bad++;
            $display("FAIL sync_err got err=%b v=%b slot=%0d data=%h lk=%b expected 1 0 1 a 1",
                     sync_error1, out_valid1, slot1, out_data1, locked1);
        end
        beat(4'h1, 1'b0);
        total++;
        if (sync_error1 !== 1'b0) begin
            bad++;
            $display("FAIL sync_err_pulse got %b expected 0", sync_error1);
        end
        beat(4'h1, 1'b0);
        beat(4'h1, 1'b0);
        total++;
        if (out_valid1 !== 1'b1 || out_data1 !== 4'b1110) begin
            bad++;
            $display("FAIL sync_recover got v=%b data=%b expected v=1 data=1110",
                     out_valid1, out_data1);
        end
    endtask

    task automatic test_sync_every;
        beat(4'h0, 1'b0);
        total++;
        if (sync_error1 !== 1'b1 || locked1 !== 1'b0 || slot1 !== 2'd0) begin
            bad++;
            $display("FAIL strict_nosync got err=%b lk=%b slot=%0d expected 1 0 0",
                     sync_error1, locked1, slot1);
        end
        total++;
        if (sync_error0 !== 1'b0 || locked0 !== 1'b1 || slot0 !== 2'd1) begin
            bad++;
            $display("FAIL free_nosync got err=%b lk=%b slot=%0d expected 0 1 1",
                     sync_error0, locked0, slot0);
        end
        beat(4'h1, 1'b0);
        beat(4'h1, 1'b0);
        beat(4'h0, 1'b0);
        total++;
        if (out_valid1 !== 1'b0 || out_data1 !== 4'b1110 || locked1 !== 1'b0 || slot1 !== 2'd0) begin
            bad++;
            $display("FAIL strict_drop got v=%b data=%b lk=%b slot=%0d expected 0 1110 0 0",
                     out_valid1, out_data1, locked1, slot1);
        end
        total++;
        if (out_valid0 !== 1'b1 || out_data0 !== 4'b0110) begin
            bad++;
            $display("FAIL free_frame got v=%b data=%b expected v=1 data=0110", out_valid0, out_data0);
        end
        beat(4'h1, 1'b1);
        beat(4'h0, 1'b0);
        beat(4'h0, 1'b0);
        beat(4'h1, 1'b0);
        total++;
        if (out_valid1 !== 1'b1 || out_data1 !== 4'b1001 || locked1 !== 1'b1) begin
            bad++;
            $display("FAIL strict_relock got v=%b data=%b lk=%b expected 1 1001 1",
                     out_valid1, out_data1, locked1);
        end
    endtask

    task automatic test_gaps;
        beat(4'h0, 1'b1);
        gap(3, 1'b0);
        beat(4'h1, 1'b0);
        gap(1, 1'b1);
        total++;
        if (slot1 !== 2'd2 || sync_error1 !== 1'b0 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL gap_idle_sync got slot=%0d err=%b v=%b expected 2 0 0",
                     slot1, sync_error1, out_valid1);
        end
        beat(4'h1, 1'b0);
        gap(2, 1'b0);
        total++;
        if (slot1 !== 2'd3 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL gap_slot got slot=%0d v=%b expected 3 0", slot1, out_valid1);
        end
        beat(4'h1, 1'b0);
        total++;
        if (out_valid1 !== 1'b1 || out_data1 !== 4'b1110 || sync_error1 !== 1'b0) begin
            bad++;
            $display("FAIL gap_frame got v=%b data=%b err=%b expected 1 1110 0",
                     out_valid1, out_data1, sync_error1);
        end
    endtask

    task automatic test_mid_reset;
        beat(4'h1, 1'b1);
        beat(4'h1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({out_data1, out_valid1, slot1, locked1, sync_error1} !== 9'h000 || out_data4 !== 16'h0) begin
            bad++;
            $display("FAIL async_reset got data=%h v=%b slot=%0d lk=%b err=%b d4=%h expected all 0",
                     out_data1, out_valid1, slot1, locked1, sync_error1, out_data4);
        end
        @(negedge clk);
        reset_n = 1'b1;
        beat(4'h1, 1'b1);
        beat(4'h1, 1'b0);
        beat(4'h0, 1'b0);
        beat(4'h0, 1'b0);
        total++;
        if (out_valid1 !== 1'b1 || out_data1 !== 4'b0011) begin
            bad++;
            $display("FAIL reset_recover got v=%b data=%b expected v=1 data=0011",
                     out_valid1, out_data1);
        end
    endtask

    task automatic test_width4;
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        beat(4'h4, 1'b0);
        total++;
        if (out_valid4 !== 1'b1 || out_data4 !== 16'h4321) begin
            bad++;
            $display("FAIL width4_frame got v=%b data=%h expected v=1 data=4321",
                     out_valid4, out_data4);
        end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_back_to_back;
        test_sync_error;
        test_sync_every;
        test_gaps;
        test_mid_reset;
        test_width4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
